// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART frame serialiser with runtime format and CTS gating
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    data_bit_num_i,
    input  logic                          parity_en_i,
    input  logic                          parity_type_i,
    input  logic                          stop_bit_num_i,
    input  logic                          wr_en_i,
    input  logic [7:0]                    wr_data_i,
    input  logic                          cts_n,
    input  logic                          tx_tick,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          busy_o,
    output logic                          tx_done_o,
    output logic                          tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           push, pop, bit_end;
    logic [7:0]     head, shreg;
    logic [2:0]     bit_cnt;
    logic [1:0]     nb;
    logic           pe, par_bit, two_stop, stop_cnt;
    logic [TW-1:0]  tick_cnt;

    assign full_o  = count == (AW+1)'(FIFO_DEPTH);
    assign empty_o = count == '0;
    assign level_o = count;
    assign busy_o  = state != IDLE;
    assign push    = wr_en_i && !full_o;
    assign pop     = state == IDLE && !empty_o && !cts_n;
    assign head    = mem[rd_ptr] & (8'hFF >> (2'd3 - data_bit_num_i));
    assign bit_end = tx_tick && tick_cnt == TW'(OVERSAMPLE - 1);

    // FIFO storage, pointers, occupancy and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count      <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow_o <= wr_en_i && full_o;
        end
    end

    // frame serialiser: format is latched at pop so mid-frame input changes wait for the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_done_o <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            nb        <= '0;
            pe        <= 1'b0;
            par_bit   <= 1'b0;
            two_stop  <= 1'b0;
            stop_cnt  <= 1'b0;
        end else begin
            tx_done_o <= 1'b0;
            if (state == IDLE) begin
                if (pop) begin
                    shreg    <= head;
                    nb       <= data_bit_num_i;
                    pe       <= parity_en_i;
                    par_bit  <= ^head ^ parity_type_i;
                    two_stop <= stop_bit_num_i;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    tx       <= 1'b0;
                    state    <= START;
                end
            end else if (tx_tick) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
                if (bit_end) begin
                    case (state)
                        START: begin
                            state <= DATA;
                            tx    <= shreg[0];
                        end
                        DATA: begin
                            if (bit_cnt == {1'b0, nb} + 3'd4) begin
                                state <= pe ? PARITY : STOP;
                                tx    <= pe ? par_bit : 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= shreg >> 1;
                                tx      <= shreg[1];
                            end
                        end
                        PARITY: begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                        STOP: begin
                            if (stop_cnt == two_stop) begin
                                state     <= IDLE;
                                tx_done_o <= 1'b1;
                            end else
                                stop_cnt <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table vectors, corner sequences and randomized queue-model checks for uart_tx_fifo
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int OVS   = 16;

    logic       clk = 0, rst = 1;
    logic [1:0] dbn = 2'd3;
    logic       pe = 0, pt = 0, sb = 0, wr_en = 0, cts_n = 0, tick = 0;
    logic [7:0] wr_data = 0;
    logic       full, empty, overflow, busy, done, tx;
    logic [4:0] level;
    int         checks = 0, errors = 0, tick_mode = 0;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OVS)) dut (
        .clk(clk), .rst(rst), .data_bit_num_i(dbn), .parity_en_i(pe), .parity_type_i(pt),
        .stop_bit_num_i(sb), .wr_en_i(wr_en), .wr_data_i(wr_data), .cts_n(cts_n), .tx_tick(tick),
        .full_o(full), .empty_o(empty), .level_o(level), .overflow_o(overflow), .busy_o(busy),
        .tx_done_o(done), .tx(tx)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        tick = tick_mode == 0 ? 1'b1 : ($urandom_range(0, 2) == 0);
    end

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  dbn;
        logic        pe, pt, sb;
        logic [11:0] bits;
        int          len;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write(input logic [7:0] d);
        wr_en = 1;
        wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    function automatic void build_frame(input logic [7:0] d, input logic [1:0] nbits, input logic p_en,
                                        input logic p_odd, input logic two, output logic [11:0] f,
                                        output int len);
        int n = int'(nbits) + 5;
        logic p = 0;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            f[1+i] = d[i];
            p ^= d[i];
        end
        len = 1 + n;
        if (p_en) begin
            f[len] = p ^ p_odd;
            len++;
        end
        len += two ? 2 : 1;
    endfunction

    task automatic expect_frame(input logic [11:0] bits, input int len, input string name, output int gap);
        int n = 0, bad = 0, cnt;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        gap = n;
        if (tx !== 1'b0) begin
            chk({name, " start timeout"}, 32'(tx), 0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            cnt = 0;
            while (cnt < OVS) begin
                if (tx !== bits[i]) bad++;
                if (tick) cnt++;
                @(negedge clk);
            end
        end
        chk({name, " bit errors"}, bad, 0);
        chk({name, " tx_done"}, 32'(done), 1);
    endtask

    initial begin
        logic [11:0] f;
        int len, gap, bad;
        logic [7:0] q[$];
        logic [7:0] d;
        logic rej;

        tbl[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 12'b110100101_0, 10};
        tbl[1] = '{8'h53, 2'd2, 1'b1, 1'b0, 1'b1, 12'b11010100110, 11};
        tbl[2] = '{8'h53, 2'd2, 1'b1, 1'b1, 1'b1, 12'b11110100110, 11};
        tbl[3] = '{8'hFF, 2'd0, 1'b1, 1'b1, 1'b0, 12'b10111110, 8};
        tbl[4] = '{8'hEA, 2'd1, 1'b0, 1'b0, 1'b1, 12'b111010100, 9};

        repeat (2) @(negedge clk);
        chk("reset tx", tx, 1);
        chk("reset empty", empty, 1);
        chk("reset full", full, 0);
        chk("reset level", level, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset overflow", overflow, 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            dbn = tbl[i].dbn; pe = tbl[i].pe; pt = tbl[i].pt; sb = tbl[i].sb;
            write(tbl[i].d);
            chk($sformatf("vec%0d busy before pop", i), busy, 0);
            expect_frame(tbl[i].bits, tbl[i].len, $sformatf("vec%0d", i), gap);
            chk($sformatf("vec%0d latency", i), gap, 1);
            repeat (3) @(negedge clk);
        end

        dbn = 2'd3; pe = 0; pt = 0; sb = 0;
        cts_n = 1;
        for (int i = 0; i < 16; i++) write(8'(i));
        chk("fill full", full, 1);
        chk("fill level", level, 16);
        chk("fill overflow quiet", overflow, 0);
        write(8'hEE);
        chk("overflow pulse", overflow, 1);
        chk("overflow level", level, 16);
        @(negedge clk);
        chk("overflow one cycle", overflow, 0);
        chk("cts held tx", tx, 1);
        cts_n = 0;
        for (int i = 0; i < 16; i++) begin
            build_frame(8'(i), dbn, pe, pt, sb, f, len);
            expect_frame(f, len, $sformatf("drain%0d", i), gap);
            if (i > 0) chk($sformatf("drain%0d gap", i), gap, 1);
        end
        chk("drain empty", empty, 1);

        write(8'h3C);
        fork
            begin
                build_frame(8'h3C, dbn, pe, pt, sb, f, len);
                expect_frame(f, len, "cts frame1", gap);
            end
            begin
                write(8'h96);
                repeat (68) @(negedge clk);
                cts_n = 1;
            end
        join
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("cts blocks second", bad, 0);
        chk("cts level", level, 1);
        cts_n = 0;
        build_frame(8'h96, dbn, pe, pt, sb, f, len);
        expect_frame(f, len, "cts frame2", gap);

        write(8'h11);
        write(8'h22);
        write(8'h33);
        repeat (40) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst tx", tx, 1);
        chk("midrst level", level, 0);
        chk("midrst busy", busy, 0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("midrst quiet", bad, 0);

        write(8'hC3);
        fork
            begin
                build_frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, f, len);
                expect_frame(f, len, "latched format", gap);
            end
            begin
                repeat (60) @(negedge clk);
                dbn = 2'd0;
            end
        join
        dbn = 2'd3;
        repeat (3) @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            tick_mode = r % 2;
            dbn = 2'($urandom_range(0, 3)); pe = 1'($urandom); pt = 1'($urandom); sb = 1'($urandom);
            cts_n = 1;
            rej = 0;
            for (int k = $urandom_range(1, 20); k > 0; k--) begin
                d = 8'($urandom);
                chk($sformatf("rnd%0d overflow", r), overflow, rej);
                rej = q.size() == DEPTH;
                if (!rej) q.push_back(d);
                write(d);
                chk($sformatf("rnd%0d ovf after write", r), overflow, rej);
            end
            chk($sformatf("rnd%0d level", r), level, q.size());
            chk($sformatf("rnd%0d full", r), full, q.size() == DEPTH);
            cts_n = 0;
            while (q.size() > 0) begin
                d = q.pop_front();
                build_frame(d, dbn, pe, pt, sb, f, len);
                expect_frame(f, len, $sformatf("rnd%0d byte %0h", r, d), gap);
            end
            chk($sformatf("rnd%0d empty", r), empty, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
